// File: rtl/wasm_instr_loader_pkg.sv
// Shared definitions for the WebAssembly instruction loader: header constant,
// default write geometry and FSM state encodings.
package wasm_instr_loader_pkg;

    // Bytes 00 61 73 6D 01 00 00 00, byte 0 in the least significant lane
    localparam logic [63:0] WASM_MAGIC   = 64'h0000_0001_6D73_6100;
    localparam int          DEF_WR_WIDTH = 32;
    localparam int          WR_BYTES     = DEF_WR_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BODY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        return WASM_MAGIC[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/wasm_byte_packer.sv
// Little-endian byte-to-word packer: a pack register collects bytes, an out
// register holds the completed word until the memory accepts it.
module wasm_byte_packer #(
    parameter int WR_WIDTH = 32,
    parameter int LOG_WIN  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WR_WIDTH-1:0] out_data,
    output logic [LOG_WIN-1:0]  out_shift_minusone,
    output logic                empty
);
    localparam int WB  = WR_WIDTH / 8;
    localparam int PCW = $clog2(WB + 1);

    logic [WR_WIDTH-1:0] pack_r;
    logic [WR_WIDTH-1:0] pack_nxt_s;
    logic [PCW-1:0]      pack_cnt_r;
    logic [PCW-1:0]      pack_cnt_nxt_s;
    logic                can_move_s;
    logic                move_s;
    logic                in_fire_s;

    // Move/accept decisions; a byte arriving on a move cycle lands in lane 0
    always_comb begin
        can_move_s     = !out_valid || out_ready;
        move_s         = can_move_s && ((pack_cnt_r == PCW'(WB)) ||
                                        (flush && (pack_cnt_r != {PCW{1'b0}})));
        in_ready       = (pack_cnt_r < PCW'(WB)) || can_move_s;
        in_fire_s      = in_valid && in_ready;
        empty          = (pack_cnt_r == {PCW{1'b0}}) && !out_valid;
        pack_nxt_s     = pack_r;
        pack_cnt_nxt_s = pack_cnt_r;
        if (move_s) begin
            pack_nxt_s     = {WR_WIDTH{1'b0}};
            pack_cnt_nxt_s = {PCW{1'b0}};
            if (in_fire_s) begin
                pack_nxt_s[7:0] = in_data;
                pack_cnt_nxt_s  = PCW'(1);
            end else begin
                pack_cnt_nxt_s = {PCW{1'b0}};
            end
        end else if (in_fire_s) begin
            pack_nxt_s[{pack_cnt_r, 3'b000} +: 8] = in_data;
            pack_cnt_nxt_s = pack_cnt_r + PCW'(1);
        end else begin
            pack_cnt_nxt_s = pack_cnt_r;
        end
    end

    // Pack and out registers
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pack_r             <= {WR_WIDTH{1'b0}};
            pack_cnt_r         <= {PCW{1'b0}};
            out_valid          <= 1'b0;
            out_data           <= {WR_WIDTH{1'b0}};
            out_shift_minusone <= {LOG_WIN{1'b0}};
        end else begin
            pack_r     <= pack_nxt_s;
            pack_cnt_r <= pack_cnt_nxt_s;
            if (move_s) begin
                out_valid          <= 1'b1;
                out_data           <= pack_r;
                out_shift_minusone <= LOG_WIN'(pack_cnt_r - PCW'(1));
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wasm_instr_loader.sv
// Loader FSM: validates the WebAssembly module header, counts body bytes,
// feeds the packer and reports done / header error / length error.
module wasm_instr_loader
    import wasm_instr_loader_pkg::*;
#(
    parameter int WR_WIDTH  = 32,
    parameter int LOG_WIN   = 2,
    parameter int MAX_BYTES = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    input  logic                s_last,
    output logic                o_we,
    output logic [WR_WIDTH-1:0] o_wr_data,
    output logic [LOG_WIN-1:0]  o_wr_shift_minusone,
    input  logic                i_wr_ready,
    output logic [CNT_W-1:0]    o_byte_count,
    output logic                o_load_done,
    output logic                o_hdr_error,
    output logic                o_len_error
);
    state_e           state_r;
    state_e           state_nxt_s;
    logic [2:0]       hdr_idx_r;
    logic [2:0]       hdr_idx_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_nxt_s;
    logic             hdr_err_nxt_s;
    logic             len_err_nxt_s;
    logic             pk_valid_s;
    logic             pk_ready_s;
    logic             pk_clr_s;
    logic             pk_flush_s;
    logic             pk_empty_s;

    // Next-state, handshake and flag logic
    always_comb begin
        state_nxt_s   = state_r;
        hdr_idx_nxt_s = hdr_idx_r;
        cnt_nxt_s     = o_byte_count;
        done_nxt_s    = o_load_done;
        hdr_err_nxt_s = o_hdr_error;
        len_err_nxt_s = o_len_error;
        s_ready       = 1'b0;
        pk_valid_s    = 1'b0;
        pk_clr_s      = 1'b0;
        pk_flush_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    state_nxt_s   = ST_HDR;
                    hdr_idx_nxt_s = 3'd0;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    done_nxt_s    = 1'b0;
                    hdr_err_nxt_s = 1'b0;
                    len_err_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_HDR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_data != hdr_byte(hdr_idx_r)) begin
                        state_nxt_s   = ST_ERR;
                        hdr_err_nxt_s = 1'b1;
                    end else if (hdr_idx_r == 3'd7) begin
                        state_nxt_s = s_last ? ST_DONE : ST_BODY;
                        done_nxt_s  = s_last;
                    end else if (s_last) begin
                        state_nxt_s   = ST_ERR;
                        hdr_err_nxt_s = 1'b1;
                    end else begin
                        hdr_idx_nxt_s = hdr_idx_r + 3'd1;
                    end
                end else begin
                    hdr_idx_nxt_s = hdr_idx_r;
                end
            end
            ST_BODY: begin
                s_ready = pk_ready_s;
                if (s_valid && pk_ready_s) begin
                    // Capacity reached: drop the byte and discard anything pending
                    if (o_byte_count >= CNT_W'(MAX_BYTES)) begin
                        state_nxt_s   = ST_ERR;
                        len_err_nxt_s = 1'b1;
                        pk_clr_s      = 1'b1;
                    end else begin
                        pk_valid_s  = 1'b1;
                        cnt_nxt_s   = o_byte_count + CNT_W'(1);
                        state_nxt_s = s_last ? ST_DRAIN : ST_BODY;
                    end
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            ST_DRAIN: begin
                pk_flush_s = 1'b1;
                if (pk_empty_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            hdr_idx_r    <= 3'd0;
            o_byte_count <= {CNT_W{1'b0}};
            o_load_done  <= 1'b0;
            o_hdr_error  <= 1'b0;
            o_len_error  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            hdr_idx_r    <= hdr_idx_nxt_s;
            o_byte_count <= cnt_nxt_s;
            o_load_done  <= done_nxt_s;
            o_hdr_error  <= hdr_err_nxt_s;
            o_len_error  <= len_err_nxt_s;
        end
    end

    wasm_byte_packer #(
        .WR_WIDTH (WR_WIDTH),
        .LOG_WIN  (LOG_WIN)
    ) u_packer (
        .clk                (i_clk),
        .rst                (i_rst),
        .clr                (pk_clr_s),
        .in_valid           (pk_valid_s),
        .in_ready           (pk_ready_s),
        .in_data            (s_data),
        .flush              (pk_flush_s),
        .out_valid          (o_we),
        .out_ready          (i_wr_ready),
        .out_data           (o_wr_data),
        .out_shift_minusone (o_wr_shift_minusone),
        .empty              (pk_empty_s)
    );

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Scoreboard bench for wasm_instr_loader: a default instance plus a
// MAX_BYTES=8 instance for the capacity-overflow case.
module tb_wasm_instr_loader;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sh;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        wr_ready;

    logic        ready_a, we_a, done_a, herr_a, lerr_a;
    logic [31:0] data_a;
    logic [1:0]  sh_a;
    logic [10:0] cnt_a;
    logic        ready_b, we_b, done_b, herr_b, lerr_b;
    logic [31:0] data_b;
    logic [1:0]  sh_b;
    logic [3:0]  cnt_b;

    int          sel;
    logic        ready_s, we_s, done_s, herr_s, lerr_s;
    logic [31:0] data_s;
    logic [10:0] cnt_s;

    int          n_tests;
    int          n_fail;
    wr_t         exp_q[$];
    logic [7:0]  body_q[$];
    logic [7:0]  hdr_bytes [8] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};

    wasm_instr_loader dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a),
        .s_valid(s_valid), .s_ready(ready_a), .s_data(s_data), .s_last(s_last),
        .o_we(we_a), .o_wr_data(data_a), .o_wr_shift_minusone(sh_a), .i_wr_ready(wr_ready),
        .o_byte_count(cnt_a), .o_load_done(done_a), .o_hdr_error(herr_a), .o_len_error(lerr_a)
    );

    wasm_instr_loader #(.MAX_BYTES(8), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b),
        .s_valid(s_valid), .s_ready(ready_b), .s_data(s_data), .s_last(s_last),
        .o_we(we_b), .o_wr_data(data_b), .o_wr_shift_minusone(sh_b), .i_wr_ready(wr_ready),
        .o_byte_count(cnt_b), .o_load_done(done_b), .o_hdr_error(herr_b), .o_len_error(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ready_s = (sel == 1) ? ready_b : ready_a;
        we_s    = (sel == 1) ? we_b    : we_a;
        done_s  = (sel == 1) ? done_b  : done_a;
        herr_s  = (sel == 1) ? herr_b  : herr_a;
        lerr_s  = (sel == 1) ? lerr_b  : lerr_a;
        data_s  = (sel == 1) ? data_b  : data_a;
        cnt_s   = (sel == 1) ? {7'd0, cnt_b} : cnt_a;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input logic [31:0] d, input logic [1:0] sh);
        wr_t w;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_we", 64'd1, 64'd0);
        end else begin
            w = exp_q.pop_front();
            check_eq("wr_data", d, w.data);
            check_eq("wr_shift", sh, w.sh);
        end
    endtask

    // Write monitor: a transfer happens at the next posedge when we && ready
    always @(negedge clk) begin
        #2;
        if (we_a && wr_ready && !rst) check_write(data_a, sh_a);
        if (we_b && wr_ready && !rst) check_write(data_b, sh_b);
    end

    task automatic model_push(input int n);
        wr_t w;
        int  k;
        for (int i = 0; i < n; i += 4) begin
            w.data = 32'd0;
            k = 0;
            while (k < 4 && (i + k) < n) begin
                w.data[8*k +: 8] = body_q[i + k];
                k++;
            end
            w.sh = 2'(k - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        #1;
        while (!ready_s && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ready_s) check_eq("ready_timeout", ready_s, 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_hdr(input int last_at);
        for (int i = 0; i <= last_at && i < 8; i++) send_byte(hdr_bytes[i], i == last_at);
    endtask

    task automatic send_body(input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) send_byte(body_q[i], last_on_end && (i == n - 1));
    endtask

    task automatic wait_end();
        int n = 0;
        #1;
        while (!(done_s || herr_s || lerr_s) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("end_reached", done_s | herr_s | lerr_s, 64'd1);
    endtask

    task automatic check_final(input logic done, input logic herr, input logic lerr, input int cnt);
        check_eq("load_done", done_s, done);
        check_eq("hdr_error", herr_s, herr);
        check_eq("len_error", lerr_s, lerr);
        check_eq("byte_count", cnt_s, cnt);
        check_eq("we_idle", we_s, 64'd0);
        check_eq("ready_idle", ready_s, 64'd0);
        check_eq("queue_empty", exp_q.size(), 64'd0);
    endtask

    task automatic clean_load(input logic [7:0] base, input int n);
        body_q.delete();
        for (int i = 0; i < n; i++) body_q.push_back(base + 8'(i));
        @(negedge clk);
        pulse_start();
        model_push(n);
        send_hdr(8);
        send_body(n, 1'b1);
        wait_end();
        check_final(1'b1, 1'b0, 1'b0, n);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; sel = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_final(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 8 body bytes 01..08 -> 04030201, 08070605
        clean_load(8'h01, 8);

        // 5 body bytes AA..EE -> DDCCBBAA (3), 000000EE (0)
        body_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        @(negedge clk);
        pulse_start();
        model_push(5);
        send_hdr(8);
        send_body(5, 1'b1);
        wait_end();
        check_final(1'b1, 1'b0, 1'b0, 5);

        // Bad header byte 2
        @(negedge clk);
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h74, 1'b0);
        #1;
        check_final(1'b0, 1'b1, 1'b0, 0);

        // Header only, s_last on index 7
        @(negedge clk);
        pulse_start();
        send_hdr(7);
        wait_end();
        check_final(1'b1, 1'b0, 1'b0, 0);

        // Truncated header
        @(negedge clk);
        pulse_start();
        send_hdr(3);
        #1;
        check_final(1'b0, 1'b1, 1'b0, 0);

        // 12 bytes with the memory stalled for 10 cycles after the first word
        body_q.delete();
        for (int i = 0; i < 12; i++) body_q.push_back(8'h10 + 8'(i));
        @(negedge clk);
        pulse_start();
        model_push(12);
        send_hdr(8);
        wr_ready = 1'b0;
        fork
            send_body(12, 1'b1);
            begin
                logic [31:0] first;
                int n = 0;
                @(negedge clk); #3;
                while (!we_s && n < 100) begin @(negedge clk); #3; n++; end
                check_eq("stall_we_seen", we_s, 64'd1);
                first = data_s;
                check_eq("stall_first_word", first, 64'h13121110);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk); #3;
                    check_eq("stall_we_hold", we_s, 64'd1);
                    check_eq("stall_data_hold", data_s, first);
                end
                check_eq("stall_ready_low", ready_s, 64'd0);
                @(negedge clk);
                wr_ready = 1'b1;
            end
        join
        wait_end();
        check_final(1'b1, 1'b0, 1'b0, 12);

        // Reset mid-body with a word pending, then a clean load
        @(negedge clk);
        pulse_start();
        send_hdr(8);
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
        @(negedge clk); #1;
        check_eq("rst_pending_we", we_s, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_final(1'b0, 1'b0, 1'b0, 0);
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        clean_load(8'h51, 7);

        // Capacity overflow on the MAX_BYTES=8 instance
        sel = 1;
        body_q.delete();
        for (int i = 0; i < 8; i++) body_q.push_back(8'hC0 + 8'(i));
        @(negedge clk);
        pulse_start();
        model_push(8);
        send_hdr(8);
        send_body(8, 1'b0);
        repeat (3) @(negedge clk);
        send_byte(8'hC8, 1'b1);
        wait_end();
        check_final(1'b0, 1'b0, 1'b1, 8);
        check_eq("other_dut_quiet", we_a, 64'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
